// File: rtl/branch_cmp_unit.sv
// Branch-condition resolver for the MIPS32 datapath.
// Decodes the branch opcode, compares A against B (signed or unsigned),
// and presents taken/diff/illegal through a one-deep valid/ready output
// register. Saturating counters track resolved and taken branches.
module branch_cmp_unit #(
  parameter int WIDTH      = 32,
  parameter int SIGNED_CMP = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [31:0]      IR,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             branch_taken,
  output logic [WIDTH:0]   diff,
  output logic             illegal_op,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [5:0] OP_BEQ = 6'h08;
  localparam logic [5:0] OP_BNE = 6'h09;
  localparam logic [5:0] OP_BGE = 6'h0A;
  localparam logic [5:0] OP_BGT = 6'h0B;
  localparam logic [5:0] OP_BLE = 6'h0C;
  localparam logic [5:0] OP_BLT = 6'h0D;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [5:0]       opcode;
  logic             unused_ir_bits;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   diff_w;
  logic             eq;
  logic             lt;
  logic             cond;
  logic             legal;
  logic             accept;
  logic             consume;

  logic             out_valid_q, out_valid_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  assign opcode         = IR[31:26];
  assign unused_ir_bits = ^IR[25:0];

  // Extending to WIDTH+1 bits keeps the subtraction overflow-free. With a
  // zero-extension the operands are non-negative in WIDTH+1 signed terms,
  // so the sign bit of the difference yields A<B in either mode.
  assign ext_a  = {((SIGNED_CMP != 0) ? A[WIDTH-1] : 1'b0), A};
  assign ext_b  = {((SIGNED_CMP != 0) ? B[WIDTH-1] : 1'b0), B};
  assign diff_w = ext_a - ext_b;
  assign eq     = (A == B);
  assign lt     = diff_w[WIDTH];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = out_valid_q && out_ready;

  // Opcode decode and branch condition select.
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = !eq;
      OP_BGE:  cond = !lt;
      OP_BGT:  cond = !lt && !eq;
      OP_BLE:  cond = lt || eq;
      OP_BLT:  cond = lt;
      default: legal = 1'b0;
    endcase
  end

  // Output register and handshake; flush wins over any accept or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    diff_d      = diff_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      taken_d     = cond && legal;
      illegal_d   = !legal;
      diff_d      = diff_w;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating performance counters, bumped only on accepted legal beats.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (accept && legal) begin
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (cond && (tk_cnt_q != CNT_MAX)) tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      diff_q      <= '0;
      br_cnt_q    <= '0;
      tk_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      diff_q      <= diff_d;
      br_cnt_q    <= br_cnt_d;
      tk_cnt_q    <= tk_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign branch_taken = taken_q;
  assign illegal_op   = illegal_q;
  assign diff         = diff_q;
  assign br_count     = br_cnt_q;
  assign taken_count  = tk_cnt_q;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Bench for branch_cmp_unit: signed, unsigned and 2-bit-counter instances
// share one stimulus stream and are compared against an integer model.
module tb_branch_cmp_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] A, B, IR;

  logic        rdy_s, ov_s, tk_s, ill_s;
  logic [32:0] diff_s;
  logic [15:0] brc_s, tkc_s;
  logic        rdy_u, ov_u, tk_u, ill_u;
  logic [32:0] diff_u;
  logic [15:0] brc_u, tkc_u;
  logic        rdy_c, ov_c, tk_c, ill_c;
  logic [32:0] diff_c;
  logic [1:0]  brc_c, tkc_c;

  always #5 clk = ~clk;

  branch_cmp_unit #(.WIDTH(32), .SIGNED_CMP(1), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .A(A), .B(B),
    .IR(IR), .flush(flush), .out_valid(ov_s), .out_ready(out_ready),
    .branch_taken(tk_s), .diff(diff_s), .illegal_op(ill_s),
    .br_count(brc_s), .taken_count(tkc_s));

  branch_cmp_unit #(.WIDTH(32), .SIGNED_CMP(0), .CNT_W(16)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .A(A), .B(B),
    .IR(IR), .flush(flush), .out_valid(ov_u), .out_ready(out_ready),
    .branch_taken(tk_u), .diff(diff_u), .illegal_op(ill_u),
    .br_count(brc_u), .taken_count(tkc_u));

  branch_cmp_unit #(.WIDTH(32), .SIGNED_CMP(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .A(A), .B(B),
    .IR(IR), .flush(flush), .out_valid(ov_c), .out_ready(out_ready),
    .branch_taken(tk_c), .diff(diff_c), .illegal_op(ill_c),
    .br_count(brc_c), .taken_count(tkc_c));

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state
  bit          m_valid, m_tk_s, m_tk_u, m_ill;
  logic [32:0] m_d_s, m_d_u;
  int          m_br, m_tc, m_br_c, m_tc_c;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b;
    bit          tk_s;
    logic [32:0] d_s;
    bit          tk_u;
    logic [32:0] d_u;
    bit          ill;
  } vec_t;

  vec_t       vecs[8];
  logic [5:0] ops[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic void ref_eval(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit sgn,
                                   output bit taken, output logic [32:0] d,
                                   output bit ill);
    longint av, bv, t;
    av = sgn ? longint'($signed(a)) : longint'(a);
    bv = sgn ? longint'($signed(b)) : longint'(b);
    t  = av - bv;
    d  = t[32:0];
    ill = 1'b0;
    taken = 1'b0;
    case (op)
      6'h08: taken = (av == bv);
      6'h09: taken = (av != bv);
      6'h0A: taken = (av >= bv);
      6'h0B: taken = (av > bv);
      6'h0C: taken = (av <= bv);
      6'h0D: taken = (av < bv);
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic reset_model();
    m_valid = 0; m_tk_s = 0; m_tk_u = 0; m_ill = 0;
    m_d_s = '0; m_d_u = '0;
    m_br = 0; m_tc = 0; m_br_c = 0; m_tc_c = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov_s"}, 64'(ov_s), 64'd0);
    chk({tag, "_ov_u"}, 64'(ov_u), 64'd0);
    chk({tag, "_tk_s"}, 64'(tk_s), 64'd0);
    chk({tag, "_ill_s"}, 64'(ill_s), 64'd0);
    chk({tag, "_diff_s"}, 64'(diff_s), 64'd0);
    chk({tag, "_brc_s"}, 64'(brc_s), 64'd0);
    chk({tag, "_tkc_s"}, 64'(tkc_s), 64'd0);
    chk({tag, "_brc_c"}, 64'(brc_c), 64'd0);
    chk({tag, "_tkc_c"}, 64'(tkc_c), 64'd0);
  endtask

  // One clock: check in_ready before the edge, advance model, check after.
  task automatic cycle();
    bit          exp_rdy, acc, t_s, t_u, il;
    logic [32:0] d_s, d_u;
    #1;
    exp_rdy = !m_valid || out_ready;
    chk("in_ready_s", 64'(rdy_s), 64'(exp_rdy));
    chk("in_ready_u", 64'(rdy_u), 64'(exp_rdy));
    chk("in_ready_c", 64'(rdy_c), 64'(exp_rdy));
    acc = in_valid && exp_rdy && !flush;
    ref_eval(IR[31:26], A, B, 1'b1, t_s, d_s, il);
    ref_eval(IR[31:26], A, B, 1'b0, t_u, d_u, il);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_tk_s = t_s; m_tk_u = t_u; m_ill = il;
      m_d_s = d_s; m_d_u = d_u;
      if (!il) begin
        m_br = sat(m_br + 1, 65535); m_br_c = sat(m_br_c + 1, 3);
        if (t_s) begin m_tc = sat(m_tc + 1, 65535); m_tc_c = sat(m_tc_c + 1, 3); end
      end
    end else if (m_valid && out_ready) m_valid = 0;
    #1;
    chk("out_valid_s", 64'(ov_s), 64'(m_valid));
    chk("out_valid_u", 64'(ov_u), 64'(m_valid));
    if (m_valid) begin
      chk("taken_s", 64'(tk_s), 64'(m_tk_s));
      chk("diff_s", 64'(diff_s), 64'(m_d_s));
      chk("illegal_s", 64'(ill_s), 64'(m_ill));
      chk("taken_u", 64'(tk_u), 64'(m_tk_u));
      chk("diff_u", 64'(diff_u), 64'(m_d_u));
    end
    chk("br_count_s", 64'(brc_s), 64'(m_br));
    chk("taken_count_s", 64'(tkc_s), 64'(m_tc));
    chk("br_count_c", 64'(brc_c), 64'(m_br_c));
    chk("taken_count_c", 64'(tkc_c), 64'(m_tc_c));
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    IR = {op, 26'($urandom())};
    A  = a;
    B  = b;
  endtask

  initial begin
    int br_before;
    vecs[0] = '{6'h08, 32'd5, 32'd5, 1'b1, 33'h0, 1'b1, 33'h0, 1'b0};
    vecs[1] = '{6'h0D, 32'hFFFFFFFF, 32'd1, 1'b1, 33'h1FFFFFFFE, 1'b0, 33'h0FFFFFFFE, 1'b0};
    vecs[2] = '{6'h0B, 32'd7, 32'd3, 1'b1, 33'h4, 1'b1, 33'h4, 1'b0};
    vecs[3] = '{6'h09, 32'd3, 32'd3, 1'b0, 33'h0, 1'b0, 33'h0, 1'b0};
    vecs[4] = '{6'h0A, 32'h80000000, 32'h7FFFFFFF, 1'b0, 33'h100000001, 1'b1, 33'h000000001, 1'b0};
    vecs[5] = '{6'h0C, 32'd0, 32'd0, 1'b1, 33'h0, 1'b1, 33'h0, 1'b0};
    vecs[6] = '{6'h23, 32'd0, 32'd0, 1'b0, 33'h0, 1'b0, 33'h0, 1'b1};
    vecs[7] = '{6'h0D, 32'd1, 32'hFFFFFFFF, 1'b0, 33'h000000002, 1'b1, 33'h100000002, 1'b0};
    ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h00, 6'h23, 6'h3F};

    // Reset held with a valid beat presented
    rst = 0; in_valid = 1; flush = 0; out_ready = 1;
    drive(6'h08, 32'd5, 32'd5);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1;

    // First accept after release
    cycle();
    chk("first_taken", 64'(tk_s), 64'd1);
    chk("first_diff", 64'(diff_s), 64'd0);
    chk("first_br", 64'(brc_s), 64'd1);
    chk("first_tk", 64'(tkc_s), 64'd1);

    // Table vectors, back-to-back accepts
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      cycle();
      chk($sformatf("vec%0d_valid", i), 64'(ov_s), 64'd1);
      chk($sformatf("vec%0d_tk_s", i), 64'(tk_s), 64'(vecs[i].tk_s));
      chk($sformatf("vec%0d_diff_s", i), 64'(diff_s), 64'(vecs[i].d_s));
      chk($sformatf("vec%0d_tk_u", i), 64'(tk_u), 64'(vecs[i].tk_u));
      chk($sformatf("vec%0d_diff_u", i), 64'(diff_u), 64'(vecs[i].d_u));
      chk($sformatf("vec%0d_ill", i), 64'(ill_s), 64'(vecs[i].ill));
    end

    // Back-pressure: BGT result held while a BNE beat waits
    drive(6'h0B, 32'd7, 32'd3);
    cycle();
    drive(6'h09, 32'd1, 32'd2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_valid", 64'(ov_s), 64'd1);
      chk("bp_in_ready", 64'(rdy_s), 64'd0);
      chk("bp_taken", 64'(tk_s), 64'd1);
      chk("bp_diff", 64'(diff_s), 64'd4);
    end
    out_ready = 1;
    cycle();
    chk("bp_load_valid", 64'(ov_s), 64'd1);
    chk("bp_load_taken", 64'(tk_s), 64'd1);
    chk("bp_load_diff", 64'(diff_s), 64'h1FFFFFFFF);

    // Flush drops the concurrent BLE beat
    drive(6'h0A, 32'd5, 32'd5);
    cycle();
    br_before = m_br;
    drive(6'h0C, 32'd1, 32'd2);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", 64'(ov_s), 64'd0);
    chk("flush_br", 64'(brc_s), 64'(br_before));
    in_valid = 0;
    cycle();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      if ($urandom_range(0, 4) == 0) b = a;
      drive(ops[$urandom_range(0, 8)], a, b);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      cycle();
    end
    flush = 0; out_ready = 1;

    // Asynchronous reset while a result is held
    drive(6'h08, 32'd9, 32'd9);
    in_valid = 1; out_ready = 0;
    cycle();
    #2 rst = 0;
    #1;
    chk("async_rst_valid", 64'(ov_s), 64'd0);
    reset_model();
    @(posedge clk);
    #1;
    chk_reset("async_rst");
    rst = 1; out_ready = 1;

    // Saturation of the 2-bit counters
    drive(6'h08, 32'd5, 32'd5);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i >= 5) begin
        chk("sat_br_c", 64'(brc_c), 64'd3);
        chk("sat_tk_c", 64'(tkc_c), 64'd3);
        chk("sat_br_s", 64'(brc_s), 64'(i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/branch_cmp_unit.md
Name: branch_cmp_unit

Overview:
Parametrised, registered branch-condition resolver for the MIPS32 datapath. It decodes the branch opcode from the instruction word and compares two WIDTH-bit operands, signed or unsigned. It returns taken/not-taken, the registered difference A-B and an illegal-opcode flag through a valid/ready output register. A pipeline flush input and saturating branch/taken performance counters are included.

Parameters:
WIDTH, 32, operand width in bits (>=2)
SIGNED_CMP, 1, 1 = relational ops compare two's-complement; 0 = unsigned
CNT_W, 16, width of performance counters (>=1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  operand/instruction beat valid
in_ready  output  1  unit can accept a beat this cycle
A  input  WIDTH  first operand (rs)
B  input  WIDTH  second operand (rt)
IR  input  32  instruction word; opcode = IR[31:26]
flush  input  1  kill held result and any accepted beat this cycle
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer accepts result
branch_taken  output  1  condition true
diff  output  WIDTH+1  A-B, sign/zero-extended per SIGNED_CMP
illegal_op  output  1  opcode not in branch set (result not-taken)
br_count  output  CNT_W  branches resolved (legal opcodes), saturating
taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Reset (rst=0, async): out_valid, branch_taken, illegal_op=0; diff=0; br_count, taken_count=0. Release is synchronous to the next clk edge.
- Opcode map:
  - 0x08 BEQ: A==B
  - 0x09 BNE: A!=B
  - 0x0A BGE: A>=B
  - 0x0B BGT: A>B
  - 0x0C BLE: A<=B
  - 0x0D BLT: A<B
  - Any other opcode: illegal_op=1, branch_taken=0; the result still completes the handshake.
- Relational compares use signed or unsigned interpretation per SIGNED_CMP. Equality is independent of SIGNED_CMP.
- diff = ext(A) - ext(B), computed at WIDTH+1 bits so it cannot overflow. ext is sign-extend if SIGNED_CMP=1, zero-extend otherwise.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready && !flush. The result is registered on that edge, so out_valid=1 on the next cycle (latency 1).
  - The result holds stable while out_valid && !out_ready.
  - A consume (out_valid && out_ready) with no new accept clears out_valid.
  - A simultaneous consume and accept loads the new result, and out_valid stays 1.
- flush (synchronous):
  - On the next edge out_valid=0.
  - Any in_valid beat in the same cycle is dropped: no result, no counter update.
  - Counters are not cleared by flush.
- Counters:
  - br_count increments on each accept of a legal opcode.
  - taken_count also increments when that accept is taken.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Inputs are ignored unless accepted. No X propagation: A, B and IR are sampled only on accept.
- Reset asserted mid-transaction discards the held result immediately (out_valid=0 asynchronously).

Test Plan:
- Reset: rst=0 with in_valid=1, then release -> all outputs 0; first accept of BEQ A=5 B=5 -> next cycle out_valid=1, branch_taken=1, diff=0, br_count=1, taken_count=1.
- Signed relational, SIGNED_CMP=1, WIDTH=32:
  - BLT A=0xFFFFFFFF B=1 -> taken=1, diff=0x1FFFFFFFE.
  - Same with SIGNED_CMP=0 -> taken=0, diff=0x0FFFFFFFE.
- Back-pressure: out_ready=0 for 3 cycles after a BGT 7>3 result -> out_valid, branch_taken=1, in_ready=0 held. A new BNE beat stays pending until out_ready=1, then is loaded the same cycle; out_valid never drops.
- Flush: accept BGE, then assert flush with in_valid=1 (BLE) -> next cycle out_valid=0; br_count unchanged by the dropped BLE.
- Illegal opcode 0x23 A=B=0 -> out_valid=1, illegal_op=1, branch_taken=0, br_count unchanged.
- Saturation, CNT_W=2: 5 consecutive taken BEQ -> br_count=3, taken_count=3; 6th accept keeps 3, no wrap.
